// File: rtl/sram_pkg.sv
// Shared constants and types for the two-master SRAM arbiter.
// Enable levels are active-low because the SRAM strobes are active-low.
package sram_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_BURST_MAX = 4;

  localparam logic ENA    = 1'b0;
  localparam logic DISENA = 1'b1;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic   rd;
    owner_t own;
  } tag_t;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way winner selection: round-robin or fixed priority to m0,
// with a burst limit that hands a tie to the other side after BURST_MAX grants.
module sram_rr_pick
  import sram_pkg::*;
#(
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ena,
  input  logic i_mode,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  owner_t             r_last;
  logic   [CNT_W-1:0] r_cnt;
  logic               w_limit;
  logic               w_gnt_vld;
  owner_t             w_tie_win;
  owner_t             w_win;

  // On a tie the counter forces the other side in once the current owner has used its burst.
  always_comb begin
    w_limit   = (r_cnt >= CNT_W'(BURST_MAX));
    w_tie_win = (i_mode && !w_limit) ? OWN_M0 : owner_t'(~r_last);
    if (i_req0 && i_req1) begin
      w_win = w_tie_win;
    end else if (i_req1) begin
      w_win = OWN_M1;
    end else begin
      w_win = OWN_M0;
    end
    w_gnt_vld = reset_n & i_ena & (i_req0 | i_req1);
    o_gnt0    = w_gnt_vld & (w_win == OWN_M0);
    o_gnt1    = w_gnt_vld & (w_win == OWN_M1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= OWN_M1;
      r_cnt  <= '0;
    end else if (w_gnt_vld) begin
      r_last <= w_win;
      if (w_win != r_last) begin
        r_cnt <= CNT_W'(1);
      end else if (!w_limit) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_arb.sv
// Two-master arbiter in front of a synchronous single-port SRAM.
// One access per cycle; reads return three cycles after their grant.
module sram_arb
  import sram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic              arb_mode,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_clk,
  output logic              s_cen,
  output logic              s_wen,
  output logic              s_oen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_ddata,
  input  logic [DATA_W-1:0] s_qdata,
  output logic              busy
);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic              r_cen;
  logic              r_wen;
  logic              r_oen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_ddata;
  tag_t              r_tag1;
  tag_t              r_tag2;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  sram_rr_pick #(
    .BURST_MAX(BURST_MAX)
  ) u_pick (
    .clk    (clk),
    .reset_n(reset_n),
    .i_ena  (ena),
    .i_mode (arb_mode),
    .i_req0 (m0_req),
    .i_req1 (m1_req),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  always_comb begin
    w_any   = w_gnt0 | w_gnt1;
    w_we    = w_gnt1 ? m1_we    : m0_we;
    w_addr  = w_gnt1 ? m1_addr  : m0_addr;
    w_wdata = w_gnt1 ? m1_wdata : m0_wdata;
  end

  // Address and write data hold their last value on idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cen   <= DISENA;
      r_wen   <= DISENA;
      r_oen   <= DISENA;
      r_addr  <= '0;
      r_ddata <= '0;
    end else if (w_any) begin
      r_cen   <= ENA;
      r_wen   <= w_we ? ENA : DISENA;
      r_oen   <= w_we ? DISENA : ENA;
      r_addr  <= w_addr;
      r_ddata <= w_wdata;
    end else begin
      r_cen   <= DISENA;
      r_wen   <= DISENA;
      r_oen   <= DISENA;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag1    <= '{rd: 1'b0, own: OWN_M0};
      r_tag2    <= '{rd: 1'b0, own: OWN_M0};
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_tag1    <= '{rd: w_any & ~w_we, own: (w_gnt1 ? OWN_M1 : OWN_M0)};
      r_tag2    <= r_tag1;
      r_rvalid0 <= r_tag2.rd & (r_tag2.own == OWN_M0);
      r_rvalid1 <= r_tag2.rd & (r_tag2.own == OWN_M1);
      if (r_tag2.rd && r_tag2.own == OWN_M0) r_rdata0 <= s_qdata;
      if (r_tag2.rd && r_tag2.own == OWN_M1) r_rdata1 <= s_qdata;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign s_clk     = clk;
  assign s_cen     = r_cen;
  assign s_wen     = r_wen;
  assign s_oen     = r_oen;
  assign s_addr    = r_addr;
  assign s_ddata   = r_ddata;
  assign busy      = r_tag1.rd | r_tag2.rd;

endmodule
